// File: rtl/move_sched_pkg.sv
// Shared definitions for the move scheduler: FSM encodings and the packed
// FIFO entry layout {dir, increment, incr_incr, duration}.
package move_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    localparam int DEF_INC_W = 64;
    localparam int DEF_DUR_W = 32;

    // Default-width view of one entry; field order matches the offset helpers.
    typedef struct packed {
        logic                 dir;
        logic [DEF_INC_W-1:0] increment;
        logic [DEF_INC_W-1:0] incr_incr;
        logic [DEF_DUR_W-1:0] duration;
    } move_entry_t;

    function automatic int entry_w(input int inc_w, input int dur_w);
        return 1 + 2 * inc_w + dur_w;
    endfunction

    function automatic int dur_lsb();
        return 0;
    endfunction

    function automatic int incr_incr_lsb(input int dur_w);
        return dur_w;
    endfunction

    function automatic int increment_lsb(input int inc_w, input int dur_w);
        return dur_w + inc_w;
    endfunction

    function automatic int dir_bit(input int inc_w, input int dur_w);
        return dur_w + 2 * inc_w;
    endfunction

    localparam int DEF_ENTRY_W = entry_w(DEF_INC_W, DEF_DUR_W);

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO of packed move entries; head is visible combinationally,
// occupancy counter decides full/empty so pointers can wrap freely.
module move_fifo #(
    parameter int DEPTH_BITS = 2,
    parameter int W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
    logic                    do_push, do_pop;

    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/move_scheduler.sv
// Queues motion segments and holds each on the DDA for its tick count.
// Define MOVE_SCHEDULER_HALT_EN to add the halt input (abort + flush).
module move_scheduler
    import move_sched_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int INC_W      = 64,
    parameter int DUR_W      = 32
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_dir,
    input  logic [INC_W-1:0]      wr_increment,
    input  logic [INC_W-1:0]      wr_incr_incr,
    input  logic [DUR_W-1:0]      wr_duration,
    input  logic                  tick,
`ifdef MOVE_SCHEDULER_HALT_EN
    input  logic                  halt,
`endif
    output logic                  dda_load,
    output logic                  dda_run,
    output logic                  dda_dir,
    output logic [INC_W-1:0]      dda_increment,
    output logic [INC_W-1:0]      dda_incr_incr,
    output logic                  buffer_dtr,
    output logic                  move_done,
    output logic [DEPTH_BITS:0]   pending
);
    localparam int EW      = entry_w(INC_W, DUR_W);
    localparam int DUR_L   = dur_lsb();
    localparam int IINC_L  = incr_incr_lsb(DUR_W);
    localparam int INC_L   = increment_lsb(INC_W, DUR_W);
    localparam int DIR_B   = dir_bit(INC_W, DUR_W);

    logic          halt_i;
    logic          full, empty, push, pop, seg_end;
    logic [EW-1:0] head, wr_entry;
    logic [DUR_W-1:0] remaining;
    sched_state_t  state;

`ifdef MOVE_SCHEDULER_HALT_EN
    assign halt_i = halt;
`else
    assign halt_i = 1'b0;
`endif

    assign wr_ready   = !full && !halt_i;
    assign buffer_dtr = wr_ready;
    assign push       = wr_valid && wr_ready;
    assign wr_entry   = {wr_dir, wr_increment, wr_incr_incr, wr_duration};

    // Duration 0 and 1 both finish on the first tick.
    assign seg_end = (state == ST_RUN) && tick && (remaining <= DUR_W'(1));
    assign pop     = !halt_i && !empty && ((state == ST_IDLE) || seg_end);

    move_fifo #(
        .DEPTH_BITS (DEPTH_BITS),
        .W          (EW)
    ) u_fifo (
        .clk   (CLK),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (halt_i),
        .din   (wr_entry),
        .dout  (head),
        .count (pending),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            dda_load      <= 1'b0;
            dda_run       <= 1'b0;
            dda_dir       <= 1'b0;
            dda_increment <= '0;
            dda_incr_incr <= '0;
            move_done     <= 1'b0;
        end else begin
            dda_load  <= 1'b0;
            move_done <= 1'b0;
            if (halt_i) begin
                state     <= ST_IDLE;
                remaining <= '0;
                dda_run   <= 1'b0;
            end else begin
                if (seg_end) begin
                    move_done <= 1'b1;
                    if (empty) begin
                        state   <= ST_IDLE;
                        dda_run <= 1'b0;
                    end
                end else if (state == ST_RUN && tick) begin
                    remaining <= remaining - DUR_W'(1);
                end
                if (pop) begin
                    state         <= ST_RUN;
                    dda_load      <= 1'b1;
                    dda_run       <= 1'b1;
                    dda_dir       <= head[DIR_B];
                    dda_increment <= head[INC_L +: INC_W];
                    dda_incr_incr <= head[IINC_L +: INC_W];
                    remaining     <= head[DUR_L +: DUR_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: single, back-to-back, full/wrap,
// zero duration, halt (when built with MOVE_SCHEDULER_HALT_EN), async reset.
module tb_move_scheduler;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_dir = 1'b0;
    logic [63:0] wr_increment = '0;
    logic [63:0] wr_incr_incr = '0;
    logic [31:0] wr_duration = '0;
    logic        tick = 1'b0;
`ifdef MOVE_SCHEDULER_HALT_EN
    logic        halt = 1'b0;
`endif
    logic        dda_load, dda_run, dda_dir, buffer_dtr, move_done;
    logic [63:0] dda_increment, dda_incr_incr;
    logic [2:0]  pending;

    int checks = 0;
    int failures = 0;
    int md_cnt = 0;

    always #5 CLK = ~CLK;

    move_scheduler dut (
        .CLK           (CLK),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_dir        (wr_dir),
        .wr_increment  (wr_increment),
        .wr_incr_incr  (wr_incr_incr),
        .wr_duration   (wr_duration),
        .tick          (tick),
`ifdef MOVE_SCHEDULER_HALT_EN
        .halt          (halt),
`endif
        .dda_load      (dda_load),
        .dda_run       (dda_run),
        .dda_dir       (dda_dir),
        .dda_increment (dda_increment),
        .dda_incr_incr (dda_incr_incr),
        .buffer_dtr    (buffer_dtr),
        .move_done     (move_done),
        .pending       (pending)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later and inputs change there.
    task automatic step();
        @(posedge CLK);
        #1;
        if (move_done) md_cnt++;
    endtask

    task automatic put(input logic d, input logic [63:0] inc, input logic [31:0] dur);
        wr_valid     = 1'b1;
        wr_dir       = d;
        wr_increment = inc;
        wr_incr_incr = inc + 64'd1;
        wr_duration  = dur;
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    logic [63:0] exp_inc;

    initial begin
        // Reset values
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_dtr", 64'(buffer_dtr), 64'd1);
        chk("rst_run", 64'(dda_run), 64'd0);
        chk("rst_load", 64'(dda_load), 64'd0);
        chk("rst_done", 64'(move_done), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_inc", dda_increment, 64'd0);
        step();
        reset = 1'b0;
        step();

        // Single segment, tick every 4 cycles
        put(1'b1, 64'h10, 32'd3);
        step();
        wr_valid = 1'b0;
        chk("s1_pending", 64'(pending), 64'd1);
        chk("s1_load_early", 64'(dda_load), 64'd0);
        step();
        chk("s1_load", 64'(dda_load), 64'd1);
        chk("s1_run", 64'(dda_run), 64'd1);
        chk("s1_inc", dda_increment, 64'h10);
        chk("s1_iinc", dda_incr_incr, 64'h11);
        chk("s1_dir", 64'(dda_dir), 64'd1);
        step();
        chk("s1_load_fall", 64'(dda_load), 64'd0);
        md_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            step();
            tick_step();
            chk($sformatf("s1_done_t%0d", i), 64'(move_done), (i == 3) ? 64'd1 : 64'd0);
            chk($sformatf("s1_run_t%0d", i), 64'(dda_run), (i < 3) ? 64'd1 : 64'd0);
            step();
        end
        chk("s1_done_pulse", 64'(move_done), 64'd0);
        chk("s1_md_cnt", 64'(md_cnt), 64'd1);
        chk("s1_inc_held", dda_increment, 64'h10);

        // Back to back: dur 2 then dur 1
        md_cnt = 0;
        put(1'b1, 64'h20, 32'd2);
        step();
        put(1'b0, 64'h30, 32'd1);
        step();
        wr_valid = 1'b0;
        chk("bb_pending", 64'(pending), 64'd1);
        chk("bb_loadA", 64'(dda_load), 64'd1);
        chk("bb_incA", dda_increment, 64'h20);
        tick_step();
        chk("bb_t1_done", 64'(move_done), 64'd0);
        tick_step();
        chk("bb_t2_done", 64'(move_done), 64'd1);
        chk("bb_t2_load", 64'(dda_load), 64'd1);
        chk("bb_t2_dir", 64'(dda_dir), 64'd0);
        chk("bb_t2_inc", dda_increment, 64'h30);
        chk("bb_t2_run", 64'(dda_run), 64'd1);
        tick_step();
        chk("bb_t3_done", 64'(move_done), 64'd1);
        chk("bb_t3_run", 64'(dda_run), 64'd0);
        step();
        chk("bb_md_cnt", 64'(md_cnt), 64'd2);

        // Full and pointer wrap
        put(1'b1, 64'h100, 32'd1);
        step();
        wr_valid = 1'b0;
        step();
        chk("fw_run", 64'(dda_run), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, 64'h100 + 64'(i), 32'd1);
            step();
        end
        wr_valid = 1'b0;
        #1;
        chk("fw_pending4", 64'(pending), 64'd4);
        chk("fw_ready0", 64'(wr_ready), 64'd0);
        chk("fw_dtr0", 64'(buffer_dtr), 64'd0);
        put(1'b0, 64'h1FF, 32'd1);
        step();
        wr_valid = 1'b0;
        chk("fw_ignored", 64'(pending), 64'd4);
        chk("fw_inc_held", dda_increment, 64'h100);
        exp_inc = 64'h101;
        for (int j = 0; j < 6; j++) begin
            tick_step();
            chk($sformatf("fw_pop%0d", j), dda_increment, exp_inc);
            chk($sformatf("fw_pend%0d", j), 64'(pending), 64'd3);
            exp_inc++;
            put(1'b1, 64'h105 + 64'(j), 32'd1);
            step();
            wr_valid = 1'b0;
        end
        for (int j = 0; j < 4; j++) begin
            tick_step();
            chk($sformatf("fw_drain%0d", j), dda_increment, exp_inc);
            chk($sformatf("fw_dpend%0d", j), 64'(pending), 64'(3 - j));
            exp_inc++;
        end
        tick_step();
        chk("fw_end_run", 64'(dda_run), 64'd0);
        chk("fw_end_done", 64'(move_done), 64'd1);

        // Zero duration behaves as duration 1
        put(1'b0, 64'h50, 32'd0);
        step();
        wr_valid = 1'b0;
        step();
        chk("z_inc", dda_increment, 64'h50);
        step();
        tick_step();
        chk("z_done", 64'(move_done), 64'd1);
        chk("z_run", 64'(dda_run), 64'd0);
        step();

`ifdef MOVE_SCHEDULER_HALT_EN
        // Halt on a completing tick with two entries pending
        put(1'b1, 64'h60, 32'd1);
        step();
        wr_valid = 1'b0;
        step();
        put(1'b1, 64'h61, 32'd1);
        step();
        put(1'b1, 64'h62, 32'd1);
        step();
        chk("h_pending2", 64'(pending), 64'd2);
        halt = 1'b1;
        tick = 1'b1;
        put(1'b1, 64'h70, 32'd1);
        #1;
        chk("h_ready_comb", 64'(wr_ready), 64'd0);
        step();
        tick = 1'b0;
        chk("h_run", 64'(dda_run), 64'd0);
        chk("h_pending", 64'(pending), 64'd0);
        chk("h_done", 64'(move_done), 64'd0);
        chk("h_load", 64'(dda_load), 64'd0);
        chk("h_ready", 64'(wr_ready), 64'd0);
        step();
        halt = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("h_ready_rel", 64'(wr_ready), 64'd1);
        step();
        chk("h_dropped", 64'(pending), 64'd0);
        chk("h_idle", 64'(dda_run), 64'd0);
`endif

        // Async reset mid-run
        put(1'b1, 64'h80, 32'd5);
        step();
        wr_valid = 1'b0;
        put(1'b1, 64'h81, 32'd5);
        step();
        wr_valid = 1'b0;
        chk("r_run_pre", 64'(dda_run), 64'd1);
        chk("r_pend_pre", 64'(pending), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_run", 64'(dda_run), 64'd0);
        chk("r_load", 64'(dda_load), 64'd0);
        chk("r_inc", dda_increment, 64'd0);
        chk("r_pending", 64'(pending), 64'd0);
        chk("r_ready", 64'(wr_ready), 64'd1);
        chk("r_dtr", 64'(buffer_dtr), 64'd1);
        step();
        reset = 1'b0;
        step();
        chk("r_stay_idle", 64'(dda_run), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
